packed_lane_sequencer: RTL and testbench

//   Sequences a packed [N-1:0][W-1:0] lane vector (e.g. a 4x28-bit bus) onto a

---
 rtl/packed_lane_sequencer.sv | 88 ++++++++
 tb/tb_packed_lane_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/packed_lane_sequencer.sv
// Serialises a packed N x W lane vector onto one W-bit valid/ready port,
// issuing only the enabled lanes in ascending index order.
module packed_lane_sequencer #(
    parameter int unsigned N  = 4,
    parameter int unsigned W  = 28,
    localparam int unsigned LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*W-1:0]    in_data,
    input  logic [N-1:0]      in_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_data,
    output logic [LW-1:0]     out_lane,
    output logic              out_last,
    output logic              busy
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                 state_q;
    logic [N-1:0][W-1:0]    held_q;
    logic [N-1:0]           pend_q;
    logic [LW-1:0]          ptr_q;

    logic                   in_accept;
    logic                   beat_accept;
    logic [N-1:0]           pend_rest;

    function automatic logic [LW-1:0] lowest_set(input logic [N-1:0] m);
        logic [LW-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (m[i]) idx = LW'(i);
        end
        return idx;
    endfunction

    always_comb begin
        out_last = (state_q == StSend);
        for (int i = 0; i < N; i++) begin
            if (pend_q[i] && (i > int'(ptr_q))) out_last = 1'b0;
        end
    end

    always_comb begin
        pend_rest        = pend_q;
        pend_rest[ptr_q] = 1'b0;
    end

    assign out_valid   = (state_q == StSend);
    assign busy        = (state_q == StSend);
    assign out_data    = held_q[ptr_q];
    assign out_lane    = ptr_q;
    assign beat_accept = out_valid & out_ready;
    // out_ready -> in_ready is the only combinational path, and only on the last beat.
    assign in_ready    = !rst && ((state_q == StIdle) || (beat_accept && out_last));
    assign in_accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            held_q  <= '0;
            pend_q  <= '0;
            ptr_q   <= '0;
        end else if (in_accept) begin
            held_q <= in_data;
            pend_q <= in_mask;
            if (in_mask == '0) begin
                state_q <= StIdle;
            end else begin
                state_q <= StSend;
                ptr_q   <= lowest_set(in_mask);
            end
        end else if (beat_accept) begin
            pend_q <= pend_rest;
            if (out_last) begin
                state_q <= StIdle;
            end else begin
                ptr_q <= lowest_set(pend_rest);
            end
        end
    end

endmodule

// File: tb/tb_packed_lane_sequencer.sv
// Scoreboard bench: expected beats are queued when a vector is accepted and
// compared as the consumer takes each beat.
module tb_packed_lane_sequencer;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 28;
    localparam int unsigned LW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [N*W-1:0]    in_data;
    logic [N-1:0]      in_mask;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic [LW-1:0]     out_lane;
    logic              out_last;
    logic              busy;

    typedef struct {
        logic [LW-1:0] lane;
        logic [W-1:0]  data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    packed_lane_sequencer #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Scoreboard: pop on a taken beat, then push the beats of a newly accepted vector.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {62'd0, out_lane}, 64'hFFFF);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_lane", 64'(out_lane), 64'(e.lane));
                    check("beat_data", 64'(out_data), 64'(e.data));
                    check("beat_last", 64'(out_last), 64'(e.last));
                end
            end
            if (in_valid && in_ready) begin
                int hi;
                hi = -1;
                for (int i = 0; i < N; i++) if (in_mask[i]) hi = i;
                for (int i = 0; i < N; i++) begin
                    if (in_mask[i]) begin
                        beat_t b;
                        b.lane = LW'(i);
                        b.data = in_data[i*W +: W];
                        b.last = (i == hi);
                        exp_q.push_back(b);
                    end
                end
            end
        end
    end

    // Present a vector until accepted; returns at the negedge one cycle after acceptance.
    task automatic send_vec(input logic [N-1:0] mask, input logic [N*W-1:0] data);
        int waited;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_mask  = mask;
        in_data  = data;
        waited   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 40) begin
                check("accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_mask  = $urandom_range(15, 0);
        in_data  = {4{28'hDEAD0BE}};
        @(negedge clk);
        check("first_beat_latency", 64'(out_valid), 64'(mask != '0));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", 64'(exp_q.size() != 0 || busy), 64'd0);
    endtask

    initial begin
        logic [W-1:0]  snap_data;
        logic [LW-1:0] snap_lane;
        logic          snap_last;
        int            stalls;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mask   = '0;
        in_data   = '0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_lane", 64'(out_lane), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // All four lanes, full throughput.
        send_vec(4'b1111, {28'h4, 28'h3, 28'h2, 28'h1});
        drain();

        // Sparse mask.
        send_vec(4'b1010, {28'hD3, 28'hC2, 28'hB1, 28'hA0});
        drain();

        // Empty mask: consumed with no beats.
        send_vec(4'b0000, {28'h9, 28'h8, 28'h7, 28'h6});
        check("empty_busy", 64'(busy), 64'd0);
        check("empty_in_ready", 64'(in_ready), 64'd1);

        // Stall three cycles on lane 2.
        send_vec(4'b0111, {28'h0, 28'h333, 28'h222, 28'h111});
        stalls = 0;
        for (int c = 0; c < 20 && busy; c++) begin
            @(posedge clk); #1;
            if (busy && out_lane == 2 && stalls < 3) begin
                out_ready = 1'b0;
                if (stalls == 0) begin
                    snap_data = out_data;
                    snap_lane = out_lane;
                    snap_last = out_last;
                end
                stalls++;
                @(negedge clk);
                check("stall_data", 64'(out_data), 64'(snap_data));
                check("stall_lane", 64'(out_lane), 64'(snap_lane));
                check("stall_last", 64'(out_last), 64'(snap_last));
                check("stall_in_ready", 64'(in_ready), 64'd0);
            end else begin
                out_ready = 1'b1;
                @(negedge clk);
            end
        end
        out_ready = 1'b1;
        check("stall_count", 64'(stalls), 64'd3);
        drain();

        // Back-to-back: second vector accepted on the first one's last beat.
        send_vec(4'b0011, {28'h0, 28'h0, 28'h5B, 28'h5A});
        send_vec(4'b0001, {28'h0, 28'h0, 28'h0, 28'hABCDEF0});
        check("b2b_lane", 64'(out_lane), 64'd0);
        check("b2b_data", 64'(out_data), 64'hABCDEF0);
        drain();

        // Reset while lane 1 is on the port.
        send_vec(4'b1111, {28'h64, 28'h63, 28'h62, 28'h61});
        @(posedge clk); #1;
        check("pre_rst_lane", 64'(out_lane), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_in_ready_after", 64'(in_ready), 64'd1);
        repeat (5) @(negedge clk);
        check("rst_mid_no_resume", 64'(busy), 64'd0);

        // A few random vectors with random consumer backpressure.
        for (int v = 0; v < 6; v++) begin
            send_vec(4'($urandom_range(15, 0)),
                     {28'($urandom), 28'($urandom), 28'($urandom), 28'($urandom)});
            for (int c = 0; c < 30 && busy; c++) begin
                @(posedge clk); #1;
                out_ready = 1'($urandom_range(1, 0));
            end
            out_ready = 1'b1;
            drain();
        end

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
